// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter
package dmem_pkg;
    localparam int DMEM_BUS_BITS = 64;
    localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_D = 3'b011;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef logic req_idx_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, favouring the requester not granted last
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic [1:0] valid,
    input  req_idx_t   last_grant,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] & (~valid[1] | last_grant);
    assign grant[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between two requesters, one access per accept
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int BUS_BITS    = DMEM_BUS_BITS,
    parameter int FUNCT3_BITS = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [1:0]                          req_valid,
    output logic [1:0]                          req_ready,
    input  logic [1:0]                          req_we,
    input  logic [1:0][BUS_BITS-1:0]            req_addr,
    input  logic [1:0][FUNCT3_BITS-1:0]         req_funct3,
    input  logic [1:0][BUS_BITS-1:0]            req_wdata,
    output logic [1:0]                          resp_valid,
    output logic [1:0][BUS_BITS-1:0]            resp_rdata,
    output logic                                mem_we,
    output logic [BUS_BITS-1:0]                 mem_addr,
    output logic [FUNCT3_BITS-1:0]              mem_funct3,
    output logic [BUS_BITS-1:0]                 mem_store_data,
    input  logic [BUS_BITS-1:0]                 mem_load_data
);
    state_t     state;
    req_idx_t   last_grant, owner, win;
    logic       we_q, accept;
    logic [1:0] grant;
    rr_arbiter2 u_rr (.valid(req_valid), .last_grant(last_grant), .grant(grant));
    assign req_ready = (!rst && state != ACCESS) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign win       = grant[1];
    // Decoded from state so an async reset drops the write strobe at once
    assign mem_we    = state == ACCESS && we_q;
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            resp_valid[i] = state == RESP && owner == req_idx_t'(i);
            resp_rdata[i] = (resp_valid[i] && !we_q) ? mem_load_data : '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            we_q           <= 1'b0;
            mem_addr       <= '0;
            mem_funct3     <= '0;
            mem_store_data <= '0;
        end else if (state == ACCESS) begin
            state <= RESP;
        end else if (accept) begin
            state          <= ACCESS;
            owner          <= win;
            last_grant     <= win;
            we_q           <= req_we[win];
            mem_addr       <= req_addr[win];
            mem_funct3     <= req_funct3[win];
            mem_store_data <= req_wdata[win];
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench with a byte-array memory model
module tb_dmem_arbiter;
    import dmem_pkg::*;
    logic             clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
    logic [1:0]       req_valid = '0, req_ready, req_we = '0, resp_valid;
    logic [1:0][63:0] req_addr = '0, req_wdata = '0, resp_rdata;
    logic [1:0][2:0]  req_funct3 = '0;
    logic             mem_we;
    logic [63:0]      mem_addr, mem_store_data, mem_load_data;
    logic [2:0]       mem_funct3;
    logic [7:0]       mem [0:255];
    int               checks = 0, failures = 0, we_cnt = 0;
    logic [63:0]      pre = 64'h1122334455667788;

    dmem_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_funct3(mem_funct3), .mem_store_data(mem_store_data), .mem_load_data(mem_load_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rd(input logic [63:0] a, input logic [2:0] f);
        logic [63:0] v = '0;
        int n = 1 << f[1:0];
        for (int j = 0; j < 8; j++) if (j < n) v[8*j +: 8] = mem[8'(a[7:0] + 8'(j))];
        if (!f[2] && n < 8) v = v | ({64{v[8*n-1]}} << (8*n));
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int j = 0; j < 256; j++) mem[j] <= 8'hFF;
            for (int j = 0; j < 8; j++) mem[16+j] <= pre[8*j +: 8];
        end else if (mem_we) begin
            for (int j = 0; j < 8; j++)
                if (j < (1 << mem_funct3[1:0])) mem[8'(mem_addr[7:0] + 8'(j))] <= mem_store_data[8*j +: 8];
        end
        mem_load_data <= rd(mem_addr, mem_funct3);
    end

    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [63:0] a,
                           input logic [2:0] f, input logic [63:0] wd);
        req_valid[i] = v; req_we[i] = we; req_addr[i] = a; req_funct3[i] = f; req_wdata[i] = wd;
    endtask

    // One isolated access from IDLE; samples ready, the ACCESS cycle and the RESP cycle
    task automatic run_one(input int i, input logic we, input logic [63:0] a, input logic [2:0] f,
                           input logic [63:0] wd, output logic [1:0] rdy, output logic acc_we,
                           output logic [1:0] acc_rv, output logic [1:0] rv,
                           output logic [63:0] own, output logic [63:0] other);
        set_req(i, 1'b1, we, a, f, wd);
        @(negedge clk); rdy = req_ready;
        tick(); req_valid[i] = 1'b0;
        @(negedge clk); acc_we = mem_we; acc_rv = resp_valid;
        tick();
        @(negedge clk); rv = resp_valid; own = resp_rdata[i]; other = resp_rdata[1-i];
        tick();
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b exp=00", resp_valid); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if ({mem_addr, mem_store_data, mem_funct3} !== '0) begin failures++; $display("FAIL reset_mem_bus got=%h/%h/%h exp=0", mem_addr, mem_store_data, mem_funct3); end
        checks++; if (resp_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        req_valid = 2'b00;
        rst = 1'b0; mem_init = 1'b0;
        tick();
    endtask

    task automatic test_single_load();
        logic [1:0] rdy, arv, rv; logic aw; logic [63:0] own, oth;
        run_one(0, 1'b0, 64'h10, F3_D, 64'h0, rdy, aw, arv, rv, own, oth);
        checks++; if (rdy !== 2'b01) begin failures++; $display("FAIL load_ready got=%b exp=01", rdy); end
        checks++; if (arv !== 2'b00) begin failures++; $display("FAIL load_early_resp got=%b exp=00", arv); end
        checks++; if (rv !== 2'b01) begin failures++; $display("FAIL load_resp_valid got=%b exp=01", rv); end
        checks++; if (own !== 64'h1122334455667788) begin failures++; $display("FAIL load_rdata got=%h exp=1122334455667788", own); end
        checks++; if (oth !== 64'h0) begin failures++; $display("FAIL load_other_rdata got=%h exp=0", oth); end
        checks++; if (we_cnt !== 0) begin failures++; $display("FAIL load_mem_we got=%0d exp=0", we_cnt); end
    endtask

    task automatic test_store_load();
        logic [1:0] rdy, arv, rv; logic aw; logic [63:0] own, oth;
        run_one(1, 1'b1, 64'h20, F3_W, 64'hDEADBEEF, rdy, aw, arv, rv, own, oth);
        checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL store_ready got=%b exp=10", rdy); end
        checks++; if (aw !== 1'b1) begin failures++; $display("FAIL store_mem_we got=%b exp=1", aw); end
        checks++; if (rv !== 2'b10) begin failures++; $display("FAIL store_resp_valid got=%b exp=10", rv); end
        checks++; if (own !== 64'h0) begin failures++; $display("FAIL store_rdata got=%h exp=0", own); end
        run_one(1, 1'b0, 64'h20, 3'b110, 64'h0, rdy, aw, arv, rv, own, oth);
        checks++; if (own !== 64'h00000000DEADBEEF) begin failures++; $display("FAIL lwu_rdata got=%h exp=00000000deadbeef", own); end
        run_one(1, 1'b0, 64'h20, F3_W, 64'h0, rdy, aw, arv, rv, own, oth);
        checks++; if (own !== 64'hFFFFFFFFDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=ffffffffdeadbeef", own); end
        checks++; if (we_cnt !== 1) begin failures++; $display("FAIL store_we_cycles got=%0d exp=1", we_cnt); end
    endtask

    task automatic test_contention();
        logic [1:0] er, ev;
        set_req(0, 1'b1, 1'b0, 64'h10, F3_D, 64'h0);
        set_req(1, 1'b1, 1'b0, 64'h20, 3'b110, 64'h0);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            er = (k % 2 == 0 && k <= 10) ? (((k / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            ev = (k % 2 == 0 && k >= 2) ? (((k / 2 - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++; if (req_ready !== er) begin failures++; $display("FAIL cont_ready k=%0d got=%b exp=%b", k, req_ready, er); end
            checks++; if (resp_valid !== ev) begin failures++; $display("FAIL cont_resp_valid k=%0d got=%b exp=%b", k, resp_valid, ev); end
            if (ev == 2'b01) begin
                checks++; if (resp_rdata !== {64'h0, 64'h1122334455667788}) begin failures++; $display("FAIL cont_rdata0 k=%0d got=%h", k, resp_rdata); end
            end
            if (ev == 2'b10) begin
                checks++; if (resp_rdata !== {64'hDEADBEEF, 64'h0}) begin failures++; $display("FAIL cont_rdata1 k=%0d got=%h", k, resp_rdata); end
            end
            tick();
            if (k == 10) req_valid = 2'b00;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] er, ev;
        set_req(0, 1'b1, 1'b0, 64'h10, F3_B, 64'h0);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            er = (k % 2 == 0 && k <= 4) ? 2'b01 : 2'b00;
            ev = (k % 2 == 0 && k >= 2) ? 2'b01 : 2'b00;
            checks++; if (req_ready !== er) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, req_ready, er); end
            checks++; if (resp_valid !== ev) begin failures++; $display("FAIL b2b_resp_valid k=%0d got=%b exp=%b", k, resp_valid, ev); end
            if (ev == 2'b01) begin
                checks++; if (resp_rdata[0] !== 64'hFFFFFFFFFFFFFF88) begin failures++; $display("FAIL b2b_rdata k=%0d got=%h exp=ffffffffffffff88", k, resp_rdata[0]); end
            end
            tick();
            if (k == 4) req_valid = 2'b00;
        end
    endtask

    task automatic test_reset_mid_store();
        set_req(0, 1'b1, 1'b1, 64'h30, F3_B, 64'hAB);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_store_ready got=%b exp=01", req_ready); end
        tick(); req_valid = 2'b00;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rst_store_access_we got=%b exp=1", mem_we); end
        rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mid_mem_we got=%b exp=0", mem_we); end
        checks++; if ({mem_addr, mem_store_data, mem_funct3} !== '0) begin failures++; $display("FAIL rst_mid_mem_bus got=%h/%h/%h exp=0", mem_addr, mem_store_data, mem_funct3); end
        tick();
        @(negedge clk);
        checks++; if (mem[8'h30] !== 8'hFF) begin failures++; $display("FAIL rst_mid_byte got=%h exp=ff", mem[8'h30]); end
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL rst_mid_resp_valid got=%b exp=00", resp_valid); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_mid_ready got=%b exp=00", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL post_rst_tie got=%b exp=01", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL post_rst_resp_valid got=%b exp=00", resp_valid); end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the data memory. It shares the single memory port between requester 0 (core load/store unit) and requester 1 (debug/loader port). It uses a valid/ready request handshake and round-robin fairness. Each accepted access is issued to memory for exactly one cycle, and the registered load result is returned to the owning requester.

## Interface
- BUS_BITS, 64, data and address width; matches the memory bus.
- FUNCT3_BITS, 3, access-size/extension code width (RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 1xx unsigned loads).
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid[i], i=0..1  in  1  request present.
- req_ready[i]  out  1  request accepted at this edge if valid.
- req_we[i]  in  1  1 = store, 0 = load.
- req_addr[i]  in  BUS_BITS  byte address.
- req_funct3[i]  in  FUNCT3_BITS  size/extension code.
- req_wdata[i]  in  BUS_BITS  store data, low bytes used.
- resp_valid[i]  out  1  one-cycle completion pulse, for stores and loads.
- resp_rdata[i]  out  BUS_BITS  load result; 0 for stores.
- mem_we  out  1  memory write enable.
- mem_addr  out  BUS_BITS  memory address.
- mem_funct3  out  FUNCT3_BITS  memory size code.
- mem_store_data  out  BUS_BITS  memory store data.
- mem_load_data  in  BUS_BITS  memory read data; registered, valid the cycle after the address is presented.

## Operation
- State machine: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready high to the arbitration winner only.
  - On accept, latch we/addr/funct3/wdata and owner into issue registers, then go to ACCESS.
- ACCESS:
  - mem_* driven from the issue registers; mem_we = latched we.
  - Memory samples at the ending edge. Always go to RESP.
- RESP:
  - resp_valid[owner] = 1.
  - resp_rdata[owner] = mem_load_data for loads, 0 for stores. The non-owner's resp_rdata = 0.
  - mem_we = 0.
  - req_ready is also asserted here to the winner, so back-to-back accesses are possible. Accept goes to ACCESS; otherwise go to IDLE.
- Arbitration:
  - Single valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - last_grant updates only on accept. Its reset value is 1, so requester 0 wins the first tie.
- mem_addr, mem_funct3 and mem_store_data hold their last issued values outside ACCESS. mem_we is high only in ACCESS, so each store writes exactly once.
- The arbiter does not check alignment or range. The memory truncates the address.
- Requesters hold their request stable while valid and not ready. The arbiter samples the request only at the accept edge.

## Timing
- Accept edge E0 → ACCESS during cycle E0–E1 → memory samples at E1 → resp_valid high in cycle E1–E2.
- Latency: 2 cycles from accept to response.
- Sustained throughput: 1 access per 2 cycles.
- Reset values: state IDLE, last_grant 1, resp_valid 0, resp_rdata 0, mem_we 0, mem_addr 0, mem_funct3 0, mem_store_data 0.
- req_ready is forced 0 while rst is high.
- Reset mid-operation: rst asserted during ACCESS drops mem_we immediately, so the store is not performed. A pending response is discarded with no resp_valid.
- Simultaneous valid in RESP: the loser waits. Its ready is low until the next IDLE/RESP arbitration, where it wins by round-robin.

## Structure
- Package dmem_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - funct3 size constants;
  - requester-index type (1 bit);
  - BUS_BITS default.
- Sub-module rr_arbiter2: combinational two-way round-robin grant from the valid vector and last_grant. last_grant is registered in dmem_arbiter.

## Test plan
- Single load: req0 load, addr 0x10, funct3 011, memory holds 0x1122334455667788 → resp_valid[0] 2 cycles after accept, rdata 0x1122334455667788; mem_we never high.
- Store then load: req1 store addr 0x20, funct3 010, wdata 0xDEADBEEF; then load funct3 110 → mem_we high exactly 1 cycle; load returns 0x00000000DEADBEEF, and funct3 010 returns 0xFFFFFFFFDEADBEEF.
- Contention: both valid continuously for 6 accesses → grants 0,1,0,1,0,1, one every 2 cycles; each resp_valid reaches only its owner.
- Back-to-back: req0 valid for 3 loads with req1 idle → accepts at E0, E2, E4; responses at E1–E2, E3–E4, E5–E6.
- Reset mid-store: assert rst during ACCESS of a store to 0x30 (wdata 0xAB, funct3 000) → mem_we falls immediately; byte 0x30 stays 0xFF; no resp_valid; all outputs at reset values.
